// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: id_ex-side request and ex_mem-side result bundle for the
// multi-cycle M-extension unit. master = pipeline, slave = ex_muldiv.
interface ex_muldiv_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  rdy;
  logic                  start_i;
  logic [2:0]            funct3_i;
  logic [XLEN-1:0]       reg1_i;
  logic [XLEN-1:0]       reg2_i;
  logic [REG_ADDR_W-1:0] wd_i;
  logic                  wreg_i;
  logic                  flush_i;
  logic                  stallreq_o;
  logic                  done_o;
  logic [REG_ADDR_W-1:0] wd_o;
  logic                  wreg_o;
  logic [XLEN-1:0]       wdata_o;

  modport master (
    output rdy, start_i, funct3_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
    input  stallreq_o, done_o, wd_o, wreg_o, wdata_o
  );

  modport slave (
    input  rdy, start_i, funct3_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
    output stallreq_o, done_o, wd_o, wreg_o, wdata_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle RV32M execute unit (MUL/MULH/MULHSU/MULHU,
// DIV/DIVU/REM/REMU). Restoring radix-2 divider and shift-add multiplier,
// one bit per cycle on magnitudes, sign fix-up on the last iteration.
// Build option: EX_MUL_1CYC_EN makes multiplies single-cycle (IDLE->DONE).
//
// state | meaning
// IDLE  | waiting for start_i, outputs cleared
// BUSY  | iterating, XLEN cycles, counter 0..XLEN-1
// DONE  | result on wd_o/wreg_o/wdata_o, done_o pulse
module ex_muldiv #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input logic        clk,
  input logic        rst,
  ex_muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam int RW = XLEN + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]         cnt;
  logic [2:0]            op;
  logic [REG_ADDR_W-1:0] wd_q;
  logic                  wreg_q;
  logic                  sgn1, sgn2;
  logic [2*XLEN-1:0]     acc;   // low half: dividend->quotient, or multiplier; high half: product
  logic [XLEN:0]         rem;
  logic [XLEN-1:0]       opb;   // divisor or multiplicand magnitude

  logic            signed1_in, signed2_in, s1_in, s2_in;
  logic            div0_in, ovf_in, direct_in, accept;
  logic [XLEN-1:0] abs1_in, abs2_in, special_res, direct_res;

  assign signed1_in = (bus.funct3_i == 3'b001) | (bus.funct3_i == 3'b010) |
                      (bus.funct3_i == 3'b100) | (bus.funct3_i == 3'b110);
  assign signed2_in = (bus.funct3_i == 3'b001) | (bus.funct3_i == 3'b100) |
                      (bus.funct3_i == 3'b110);
  assign s1_in   = signed1_in & bus.reg1_i[XLEN-1];
  assign s2_in   = signed2_in & bus.reg2_i[XLEN-1];
  assign abs1_in = s1_in ? -bus.reg1_i : bus.reg1_i;
  assign abs2_in = s2_in ? -bus.reg2_i : bus.reg2_i;

  // Divide by zero and INT_MIN / -1 bypass the iteration entirely.
  assign div0_in = bus.funct3_i[2] & (bus.reg2_i == '0);
  assign ovf_in  = bus.funct3_i[2] & ~bus.funct3_i[0] &
                   (bus.reg1_i == {1'b1, {(XLEN-1){1'b0}}}) & (bus.reg2_i == '1);
  assign special_res = div0_in ? (bus.funct3_i[1] ? bus.reg1_i : '1)
                               : (bus.funct3_i[1] ? '0 : bus.reg1_i);

`ifdef EX_MUL_1CYC_EN
  logic [2*XLEN-1:0] mul_a, mul_b, mul_p;
  assign mul_a      = {{XLEN{s1_in}}, bus.reg1_i};
  assign mul_b      = {{XLEN{s2_in}}, bus.reg2_i};
  assign mul_p      = mul_a * mul_b;
  assign direct_in  = div0_in | ovf_in | ~bus.funct3_i[2];
  assign direct_res = bus.funct3_i[2] ? special_res :
                      (bus.funct3_i[1:0] == 2'b00) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];
`else
  assign direct_in  = div0_in | ovf_in;
  assign direct_res = special_res;
`endif

  assign accept = (state == IDLE) & bus.start_i & bus.rdy & ~bus.flush_i;

  logic [XLEN+1:0]   shifted;
  logic              ge;
  logic [XLEN:0]     rem_step;
  logic [XLEN-1:0]   q_step;
  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] mul_step, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, busy_res;

  // One divide step and one multiply step, plus the signed result they imply
  always_comb begin
    shifted  = {rem, acc[XLEN-1]};
    ge       = shifted >= {2'b00, opb};
    rem_step = ge ? RW'(shifted - {2'b00, opb}) : shifted[XLEN:0];
    q_step   = {acc[XLEN-2:0], ge};
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    mul_step = {sum, acc[XLEN-1:1]};
    quot_fix = (sgn1 ^ sgn2) ? -q_step : q_step;
    rem_fix  = sgn1 ? -rem_step[XLEN-1:0] : rem_step[XLEN-1:0];
    prod_fix = (sgn1 ^ sgn2) ? -mul_step : mul_step;
    case (op)
      3'b000:          busy_res = prod_fix[XLEN-1:0];
      3'b100, 3'b101:  busy_res = quot_fix;
      3'b110, 3'b111:  busy_res = rem_fix;
      default:         busy_res = prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; flush overrides rdy
  always_comb begin
    state_nxt = state;
    if (bus.flush_i) begin
      state_nxt = IDLE;
    end else if (bus.rdy) begin
      case (state)
        IDLE:    if (bus.start_i) state_nxt = direct_in ? DONE : BUSY;
        BUSY:    if (cnt == LAST) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stall and done decode; stall drops with rst even if start_i is high
  always_comb begin
    bus.stallreq_o = ~rst & (((state == IDLE) & bus.start_i & ~bus.flush_i) | (state == BUSY));
    bus.done_o     = (state == DONE);
  end

  // Operand capture on accept, one iteration per BUSY cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0; op <= '0; wd_q <= '0; wreg_q <= 1'b0;
      sgn1 <= 1'b0; sgn2 <= 1'b0; acc <= '0; rem <= '0; opb <= '0;
    end else if (bus.flush_i) begin
      cnt <= '0;
    end else if (bus.rdy) begin
      if (accept) begin
        cnt    <= '0;
        op     <= bus.funct3_i;
        wd_q   <= bus.wd_i;
        wreg_q <= bus.wreg_i;
        sgn1   <= s1_in;
        sgn2   <= s2_in;
        acc    <= {{XLEN{1'b0}}, abs1_in};
        rem    <= '0;
        opb    <= abs2_in;
      end else if (state == BUSY) begin
        cnt <= cnt + CW'(1);
        rem <= rem_step;
        acc <= op[2] ? {acc[2*XLEN-1:XLEN], q_step} : mul_step;
      end
    end
  end

  // Result registers: loaded only on entry to DONE, zero otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wd_o <= '0; bus.wreg_o <= 1'b0; bus.wdata_o <= '0;
    end else if (bus.flush_i) begin
      bus.wd_o <= '0; bus.wreg_o <= 1'b0; bus.wdata_o <= '0;
    end else if (bus.rdy) begin
      if (accept && direct_in) begin
        bus.wd_o <= bus.wd_i; bus.wreg_o <= bus.wreg_i; bus.wdata_o <= direct_res;
      end else if (state == BUSY && cnt == LAST) begin
        bus.wd_o <= wd_q; bus.wreg_o <= wreg_q; bus.wdata_o <= busy_res;
      end else begin
        bus.wd_o <= '0; bus.wreg_o <= 1'b0; bus.wdata_o <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed test-plan ops with literal results, then random ops
// checked against a plain-arithmetic RV32M model.
module tb_ex_muldiv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_muldiv_if bus ();
  ex_muldiv dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {logic [31:0] data; logic [4:0] wd; logic wreg;} exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int base_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2]) begin
      if (b == 0) return 1;
      if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
`ifdef EX_MUL_1CYC_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  // Compare process: results against the expectation queue, zeros otherwise
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.done_o) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_done: got done_o=1 wdata=%0h required no result at %0t", bus.wdata_o, $time);
          end else begin
            e = exp_q.pop_front();
            chk("wdata", bus.wdata_o, e.data);
            chk("wd", bus.wd_o, e.wd);
            chk("wreg", bus.wreg_o, e.wreg);
          end
        end else begin
          chk("idle_wdata_zero", bus.wdata_o, 0);
          chk("idle_wd_zero", bus.wd_o, 0);
          chk("idle_wreg_zero", bus.wreg_o, 0);
        end
      end
    end
  end

  // Issue one op, check stall profile and done latency; rdy low over [lo,hi]
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wd, input logic wreg, input logic [31:0] exp,
                       input int lo, input int hi);
    exp_t e;
    int lat, got;
    lat = base_lat(f, a, b) + ((hi >= lo) ? (hi - lo + 1) : 0);
    @(negedge clk);
    bus.rdy = 1'b1; bus.start_i = 1'b1; bus.funct3_i = f;
    bus.reg1_i = a; bus.reg2_i = b; bus.wd_i = wd; bus.wreg_i = wreg;
    e.data = exp; e.wd = wd; e.wreg = wreg;
    exp_q.push_back(e);
    #1 chk("stall_c0", bus.stallreq_o, 1);
    got = -1;
    for (int c = 1; c <= lat + 5 && got < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.start_i = 1'b0; bus.reg1_i = $urandom(); bus.reg2_i = $urandom(); bus.wd_i = 5'($urandom());
      end
      bus.rdy = !(c >= lo && c <= hi);
      #1;
      if (c <= lat) chk("stallreq", bus.stallreq_o, (c < lat) ? 1 : 0);
      if (bus.done_o) got = c;
    end
    chk("done_latency", got, lat);
    if (got < 0) exp_q.delete();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f;
    logic [31:0] a, b;
    int lo, hi;
    bus.rdy = 1'b1; bus.start_i = 1'b0; bus.funct3_i = '0; bus.reg1_i = '0;
    bus.reg2_i = '0; bus.wd_i = '0; bus.wreg_i = 1'b0; bus.flush_i = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_stall", bus.stallreq_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_wdata", bus.wdata_o, 0);
    #3 rst = 1'b0;

    do_op(3'd5, 100, 7, 5'd1, 1'b1, 32'd14, 0, -1);
    do_op(3'd7, 100, 7, 5'd2, 1'b1, 32'd2, 0, -1);
    do_op(3'd4, 32'hFFFF_FFF9, 2, 5'd3, 1'b1, 32'hFFFF_FFFD, 0, -1);
    do_op(3'd6, 32'hFFFF_FFF9, 2, 5'd4, 1'b1, 32'hFFFF_FFFF, 0, -1);
    do_op(3'd5, 5, 0, 5'd5, 1'b1, 32'hFFFF_FFFF, 0, -1);
    do_op(3'd6, 5, 0, 5'd6, 1'b0, 32'd5, 0, -1);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1'b1, 32'h8000_0000, 0, -1);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b1, 32'h0, 0, -1);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd9, 1'b1, 32'h4000_0000, 0, -1);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 1'b1, 32'hFFFF_FFFF, 0, -1);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 1'b1, 32'hFFFF_FFFE, 0, -1);
    do_op(3'd0, 32'h1234_5678, 32'h10, 5'd12, 1'b1, 32'h2345_6780, 0, -1);
    do_op(3'd5, 1000, 10, 5'd13, 1'b1, 32'd100, 5, 9);

    // Flush at BUSY cycle 10, then a fresh op
    @(negedge clk);
    bus.start_i = 1'b1; bus.funct3_i = 3'd5; bus.reg1_i = 100; bus.reg2_i = 7;
    bus.wd_i = 5'd20; bus.wreg_i = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) bus.start_i = 1'b0;
      bus.flush_i = (c == 10);
      #1;
      chk("flush_stall", bus.stallreq_o, (c <= 10) ? 1 : 0);
    end
    do_op(3'd5, 9, 3, 5'd21, 1'b0, 32'd3, 0, -1);

    // Flush in IDLE blocks acceptance
    @(negedge clk);
    bus.start_i = 1'b1; bus.flush_i = 1'b1; bus.funct3_i = 3'd5; bus.reg1_i = 8; bus.reg2_i = 0;
    #1 chk("flush_idle_stall", bus.stallreq_o, 0);
    @(negedge clk);
    bus.start_i = 1'b0; bus.flush_i = 1'b0;
    repeat (3) @(negedge clk);

    // Async reset mid-BUSY
    @(negedge clk);
    bus.start_i = 1'b1; bus.funct3_i = 3'd5; bus.reg1_i = 100; bus.reg2_i = 7;
    repeat (5) begin @(negedge clk); bus.start_i = 1'b0; end
    #1 chk("busy_stall_before_rst", bus.stallreq_o, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_stall", bus.stallreq_o, 0);
    chk("async_rst_done", bus.done_o, 0);
    @(negedge clk); #3 rst = 1'b0;

    // Async reset while DONE holds a nonzero result
    do_op(3'd5, 5, 0, 5'd31, 1'b1, 32'hFFFF_FFFF, 0, -1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_done2", bus.done_o, 0);
    chk("async_rst_wd", bus.wd_o, 0);
    chk("async_rst_wreg", bus.wreg_o, 0);
    chk("async_rst_wdata", bus.wdata_o, 0);
    @(negedge clk); #3 rst = 1'b0;

    // Random ops against the model
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      lo = 0; hi = -1;
      if (base_lat(f, a, b) == 33 && $urandom_range(0, 1) == 1) begin
        lo = $urandom_range(2, 20);
        hi = lo + $urandom_range(0, 3);
      end
      do_op(f, a, b, 5'($urandom()), 1'($urandom()), model(f, a, b), lo, hi);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Multi-cycle RV32M execute unit for the M-extension ops (funct7 = 0000001 on the OP opcode): MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. It sits beside the single-cycle ALU in the EX stage and takes operands, destination and write-enable from id_ex. While an op is in flight it holds the pipeline through a stall request. It returns a one-cycle result toward ex_mem in the same wd/wreg/wdata form as the ALU path.

## Interface
- XLEN, 32, operand and result width
- REG_ADDR_W, 5, destination register address width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- rdy  in  1  global run enable; low freezes all state
- start_i  in  1  valid M-op presented by id_ex
- funct3_i  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- reg1_i  in  XLEN  rs1 operand
- reg2_i  in  XLEN  rs2 operand
- wd_i  in  REG_ADDR_W  destination register
- wreg_i  in  1  write enable
- flush_i  in  1  abort the in-flight op (branch redirect)
- stallreq_o  out  1  pipeline hold request
- done_o  out  1  result valid, one-cycle pulse
- wd_o  out  REG_ADDR_W  latched destination
- wreg_o  out  1  latched write enable, qualified by done_o
- wdata_o  out  XLEN  result

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, start_i=1, rdy=1:
  - Latch funct3, wd, wreg and the operands.
  - Signed ops store absolute values plus sign flags. MULHSU treats rs1 as signed and rs2 as unsigned.
  - Special cases go directly to DONE; everything else goes to BUSY with counter = 0.
- Special cases:
  - Divisor zero: quotient = all ones, remainder = dividend.
  - Signed overflow (dividend = 1 followed by XLEN-1 zeros, divisor = all ones): quotient = dividend, remainder = 0.
- BUSY, divide: restoring radix-2, one quotient bit per cycle, remainder register XLEN+1 bits.
- BUSY, multiply: shift-add, one multiplier bit per cycle, 2*XLEN accumulator.
- BUSY exit: after XLEN iterations (counter = XLEN-1), apply the sign fix-up, load the outputs and go to DONE.
- Sign fix-up:
  - Quotient negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Product negated when the effective operand signs differ.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- DONE: done_o=1 and outputs valid; start_i is ignored. Next state is IDLE.
- stallreq_o = (IDLE & start_i & ~flush_i) | BUSY. It is 0 in DONE, so the pipeline advances on the DONE cycle.
- Outputs are registered. wd_o, wreg_o and wdata_o are nonzero only during DONE and are 0 in IDLE and BUSY.
- flush_i has priority over everything except rst: next state IDLE, no done_o, outputs cleared. A flush in IDLE also blocks acceptance.
- rdy=0: state, counter, datapath and outputs all hold; stallreq_o keeps its value.
- rst: state IDLE, counter 0, datapath registers 0. stallreq_o, done_o, wd_o, wreg_o and wdata_o all go to 0 immediately, independent of clk.

## Timing
- Cycle 0 is the IDLE cycle with start_i sampled.
- Iterative op: BUSY during cycles 1..XLEN; DONE (done_o=1) at cycle XLEN+1. With XLEN=32, done_o is at cycle 33.
- Special-case divide: DONE at cycle 1.
- Back-to-back ops: the next op can be accepted at cycle XLEN+2, the first cycle back in IDLE.
- Each cycle with rdy=0 adds exactly one cycle of latency.
- A flush at cycle n: IDLE at n+1; stallreq_o falls at n+1, or is already 0 at n if the flush comes in IDLE.

## Configuration
- EX_MUL_1CYC_EN defined:
  - Multiplies use a single-cycle full 2*XLEN multiplier in the accept cycle and go IDLE→DONE, so done_o is at cycle 1.
  - Divides are unchanged.
- EX_MUL_1CYC_EN undefined:
  - Multiplies use the iterative shift-add path, so done_o is at cycle XLEN+1.
  - No hardware multiplier is inferred.

## Test plan
- DIVU 100/7, then REMU 100/7 (XLEN=32): done_o at cycle 33 with wdata_o=14, then 2. stallreq_o is high for cycles 0–32 and low at 33.
- DIV -7/2 and REM -7/2: results 0xFFFFFFFD and 0xFFFFFFFF.
- Divide special cases, each with done_o at cycle 1:
  - DIVU 5/0 gives 0xFFFFFFFF; REM 5/0 gives 5.
  - DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM of the same gives 0.
- Multiplies:
  - MULH 0x80000000×0x80000000 gives 0x40000000.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFE.
  - MUL 0x12345678×0x10 gives 0x23456780.
  - done_o at cycle 1 with EX_MUL_1CYC_EN, cycle 33 without.
- flush_i at BUSY cycle 10: no done_o, IDLE at cycle 11, stallreq_o=0 at cycle 11. A following DIVU 9/3 then returns 3 with wd_o/wreg_o taken from the new op.
- rdy=0 for cycles 5–9 of a DIVU 1000/10: done_o at cycle 38, result 100.
- rst asserted mid-BUSY between clock edges: all outputs 0 immediately.
